shift_issue_stage: RTL
======================

# shift_issue_stage

Two-stage valid/ready pipeline around the execute-stage shifter. Stage S1 decodes an R-type shift instruction, selects operands, registers them and drives the combinational shifter. Stage S2 captures the shifter result together with destination information for writeback. Sits between register-file read and the writeback mux; the shifter itself stays outside and is wired to the `sh_*` ports.

## Interface

- `DATA_WIDTH`, 32, datapath width; only 32 is supported.

- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `flush` input 1: synchronous pipeline kill.
- `in_valid` input 1: instruction and operands valid.
- `in_ready` output 1: S1 can accept this cycle.
- `in_instr` input 32: MIPS instruction word.
- `in_rs` input 32: GPR[rs] value.
- `in_rt` input 32: GPR[rt] value.
- `sh_A` output 32: shifter operand A, from the S1 register.
- `sh_B` output 32: shifter operand B, from the S1 register.
- `sh_op` output 2: shifter op (00 SLL, 10 SRL, 11 SRA).
- `sh_result` input 32: shifter output, combinational from `sh_*`.
- `out_valid` output 1: S2 holds a result.
- `out_ready` input 1: consumer accepts the S2 result.
- `out_result` output 32: shift result.
- `out_rd` output 5: destination register.
- `out_wen` output 1: register write enable.
- `out_illegal` output 1: instruction was not a recognised shift.

## Operation

- **Decode**
  - opcode = `instr[31:26]`, funct = `instr[5:0]`, shamt = `instr[10:6]`, rd = `instr[15:11]`.
  - Legal when opcode == 0 and funct ∈ {000000 SLL, 000010 SRL, 000011 SRA, 000100 SLLV, 000110 SRLV, 000111 SRAV}.
- **Operand select at S1 load**
  - A = `in_rt`.
  - B = funct[2] ? `in_rs` : {27'b0, shamt}. `in_rs` passes through unmasked; the shifter uses only B[4:0].
  - op = funct[1:0].
- **Illegal instructions**
  - Still flow through the pipeline. S1 stores A=0, B=0, op=00, illegal=1.
  - S2 forces `out_result`=0, `out_wen`=0, `out_illegal`=1.
- **Write enable**
  - `out_wen` = legal && rd != 0.
  - The NOP (instr 0x00000000) produces an output with `out_wen`=0 and `out_illegal`=0.
- **Pipeline control**
  - s2_free = !s2_valid || out_ready.
  - s1_adv = s1_valid && s2_free.
  - `in_ready` = !flush && (!s1_valid || s1_adv).
  - Accept = in_valid && in_ready.
- **Register updates**
  - S2 loads {sh_result, rd, wen, illegal} on s1_adv.
  - S2 clears s2_valid when out_ready && !s1_adv.
  - S1 loads on accept and clears on s1_adv without accept.
- **Flush**
  - Clears s1_valid and s2_valid on the next edge, overriding every load.
  - `in_ready`=0 during flush, so no input is consumed.
- **Reset state:** every register is 0.
  - Outputs: `out_valid`=0, `out_result`=0, `out_rd`=0, `out_wen`=0, `out_illegal`=0, `sh_A`=0, `sh_B`=0, `sh_op`=00.
  - `in_ready`=1 once `rst_n` is high.

## Timing

- **Latency:** an instruction accepted at edge N appears with `out_valid`=1 after edge N+1 when `out_ready` is held high.
- **Throughput:** 1 instruction/cycle sustained with `out_ready`=1.
- **Backpressure:**
  - With `out_ready`=0, the pipeline holds at most 2 instructions.
  - `in_ready` falls combinationally once S1 and S2 are both full.
  - S2 contents and `out_*` stay stable while `out_valid`=1 && !`out_ready`.
- **Ordering:** strictly in order. No bubbles are inserted when downstream is free.
- **Simultaneous events:**
  - Accept and S1 advance on the same edge: S1 takes the new entry and S2 takes the old S1 entry.
  - out_ready together with s1_adv: S2 is replaced, no gap.
- **Reset mid-operation:** an asynchronous `rst_n` low clears all state immediately, without waiting for a clock edge. In-flight instructions are discarded.
- **Combinational path:** `sh_result` → S2 is the only path through the external shifter. `sh_*` come directly from S1 flops.

## Test plan

- **SLL:** instr 0x00031900 (SLL rd=3, rt=3, shamt=4), `in_rt`=0x00000001, `out_ready`=1 → two edges later `out_valid`=1, `out_result`=0x00000010, `out_rd`=3, `out_wen`=1.
- **SRAV:** instr 0x00852007 (SRAV rd=4), `in_rs`=0x00000024, `in_rt`=0x80000000 → `sh_B`=0x00000024, `sh_op`=11, `out_result`=0xF8000000.
- **Backpressure:** `out_ready`=0, three back-to-back valid SRLs (shamt 1, 2, 3 on rt=0x80) → first two accepted, `in_ready`=0 on the third.
  - Raise `out_ready` → results 0x40, 0x20, 0x10 in order, no duplicates, no drops.
- **Illegal:** ADDU 0x00851021 → `out_illegal`=1, `out_wen`=0, `out_result`=0.
  - NOP 0x00000000 → `out_wen`=0, `out_illegal`=0.
- **Flush:** assert `flush` with S1 and S2 full and `in_valid`=1 → `in_ready`=0 that cycle, `out_valid`=0 after the edge, and the next SLL flows normally.
- **Reset mid-operation:** drop `rst_n` between edges with the pipeline full → all outputs 0 immediately. Release `rst_n` → `in_ready`=1, and no stale result ever appears.

Source files
------------

// File: rtl/shift_issue_stage.sv
// shift_issue_stage
//
// Two-stage valid/ready pipeline wrapped around the execute-stage shifter.
// S1 decodes an R-type shift, selects the shifter operands and registers
// them; the registered operands drive the external combinational shifter
// through the sh_* ports. S2 captures the shifter result together with the
// destination register, write enable and illegal flag for writeback.
//
// Ports
//   clk          single clock, rising edge
//   rst_n        asynchronous active-low reset
//   flush        synchronous kill of both stages
//   in_valid     upstream instruction/operands valid
//   in_ready     S1 can accept this cycle
//   in_instr     MIPS instruction word
//   in_rs        GPR[rs]
//   in_rt        GPR[rt]
//   sh_A, sh_B   shifter operands straight from S1 flops
//   sh_op        shifter op (00 SLL, 10 SRL, 11 SRA)
//   sh_result    shifter output, combinational from sh_*
//   out_valid    S2 holds a result
//   out_ready    consumer accepts the S2 result
//   out_result   shift result (0 for illegal instructions)
//   out_rd       destination register
//   out_wen      register write enable
//   out_illegal  instruction was not a recognised shift
//
// Only DATA_WIDTH = 32 is meaningful: the instruction encoding and the
// 5-bit shift amount assume a 32-bit datapath.

module shift_issue_stage #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_instr,
  input  logic [DATA_WIDTH-1:0] in_rs,
  input  logic [DATA_WIDTH-1:0] in_rt,
  output logic [DATA_WIDTH-1:0] sh_A,
  output logic [DATA_WIDTH-1:0] sh_B,
  output logic [1:0]            sh_op,
  input  logic [DATA_WIDTH-1:0] sh_result,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_result,
  output logic [4:0]            out_rd,
  output logic                  out_wen,
  output logic                  out_illegal
);

  // Instruction fields
  logic [5:0] opcode;
  logic [5:0] funct;
  logic [4:0] shamt;
  logic [4:0] dec_rd;

  // Decoded values presented to S1
  logic                  dec_legal;
  logic                  dec_wen;
  logic [DATA_WIDTH-1:0] dec_a;
  logic [DATA_WIDTH-1:0] dec_b;
  logic [1:0]            dec_op;

  // S1 state
  logic                  s1_valid;
  logic [DATA_WIDTH-1:0] s1_a;
  logic [DATA_WIDTH-1:0] s1_b;
  logic [1:0]            s1_op;
  logic [4:0]            s1_rd;
  logic                  s1_wen;
  logic                  s1_illegal;

  // S2 state
  logic                  s2_valid;
  logic [DATA_WIDTH-1:0] s2_result;
  logic [4:0]            s2_rd;
  logic                  s2_wen;
  logic                  s2_illegal;

  // Handshake terms
  logic s2_free;
  logic s1_adv;
  logic accept;

  // The rs/rt register-number fields are consumed by register-file read
  // upstream; this stage only sees the operand values.
  logic unused_reg_fields;

  assign opcode = in_instr[31:26];
  assign funct  = in_instr[5:0];
  assign shamt  = in_instr[10:6];
  assign dec_rd = in_instr[15:11];

  assign unused_reg_fields = ^in_instr[25:16];

  // Decode and operand select. Illegal instructions still travel down the
  // pipe but with zeroed operands so the shifter sees a quiet SLL-by-0.
  // For the variable forms (funct[2] set) rs goes through unmasked; the
  // shifter only looks at B[4:0].
  always_comb begin
    dec_legal = 1'b0;
    if (opcode == 6'd0) begin
      case (funct)
        6'b000000, 6'b000010, 6'b000011,
        6'b000100, 6'b000110, 6'b000111: dec_legal = 1'b1;
        default:                         dec_legal = 1'b0;
      endcase
    end

    dec_a  = '0;
    dec_b  = '0;
    dec_op = 2'b00;
    if (dec_legal) begin
      dec_a  = in_rt;
      dec_b  = funct[2] ? in_rs : {{(DATA_WIDTH-5){1'b0}}, shamt};
      dec_op = funct[1:0];
    end

    dec_wen = dec_legal && (dec_rd != 5'd0);
  end

  // Handshake. S2 can take a new entry when empty or being drained this
  // cycle; S1 advances whenever it holds something and S2 can take it.
  // in_ready is killed by flush so nothing is consumed on a flush edge.
  assign s2_free  = !s2_valid || out_ready;
  assign s1_adv   = s1_valid && s2_free;
  assign in_ready = !flush && (!s1_valid || s1_adv);
  assign accept   = in_valid && in_ready;

  // S1 register. A new instruction lands on accept (possibly on the same
  // edge the old one moves to S2); otherwise S1 empties when it advances.
  // Flush wins over everything; data flops are left alone since the valid
  // bit is what matters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s1_a       <= '0;
      s1_b       <= '0;
      s1_op      <= 2'b00;
      s1_rd      <= 5'd0;
      s1_wen     <= 1'b0;
      s1_illegal <= 1'b0;
    end else if (flush) begin
      s1_valid <= 1'b0;
    end else if (accept) begin
      s1_valid   <= 1'b1;
      s1_a       <= dec_a;
      s1_b       <= dec_b;
      s1_op      <= dec_op;
      s1_rd      <= dec_rd;
      s1_wen     <= dec_wen;
      s1_illegal <= !dec_legal;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // S2 register. Captures the shifter result as S1 advances, forcing the
  // result and write enable to zero for illegal instructions. When the
  // consumer drains S2 and nothing follows, S2 goes empty; when something
  // does follow it is simply replaced with no bubble. While stalled the
  // contents hold, keeping out_* stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid   <= 1'b0;
      s2_result  <= '0;
      s2_rd      <= 5'd0;
      s2_wen     <= 1'b0;
      s2_illegal <= 1'b0;
    end else if (flush) begin
      s2_valid <= 1'b0;
    end else if (s1_adv) begin
      s2_valid   <= 1'b1;
      s2_result  <= s1_illegal ? '0 : sh_result;
      s2_rd      <= s1_rd;
      s2_wen     <= s1_wen && !s1_illegal;
      s2_illegal <= s1_illegal;
    end else if (out_ready) begin
      s2_valid <= 1'b0;
    end
  end

  // The shifter is driven straight from S1 flops and the outputs straight
  // from S2 flops, so sh_result -> S2 is the only path through the shifter.
  assign sh_A        = s1_a;
  assign sh_B        = s1_b;
  assign sh_op       = s1_op;

  assign out_valid   = s2_valid;
  assign out_result  = s2_result;
  assign out_rd      = s2_rd;
  assign out_wen     = s2_wen;
  assign out_illegal = s2_illegal;

endmodule
